// File: rtl/rhandler_pkg.sv
// Shared types, response codes and a width helper for the multi-outstanding
// AXI4-Lite read slave driver.
package rhandler_pkg;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bits needed to index n entries; never returns less than 1.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rhandler_req_fifo.sv
// Request queue: synchronous FIFO with wrap-bit pointers, full/empty flags
// and a combinational read port showing the head entry.
module rhandler_req_fifo
  import rhandler_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2_safe(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rhandler_slave_driver_mo.sv
// Multi-outstanding AXI4-Lite read driver: queues read requests, issues up
// to MAX_OUTST ARs ahead of their R beats, returns each beat as a done pulse
// and retires reads the slave never answers after TIMEOUT_CYC idle cycles.
module rhandler_slave_driver_mo
  import rhandler_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REQ_DEPTH   = 4,
  parameter int MAX_OUTST   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              start_ready,
  output logic              done,
  output logic [DATA_W-1:0] done_data,
  output logic [1:0]        done_resp,
  output logic              done_timeout,
  output logic              err_stray,
  output logic              busy,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready
);

  localparam int OW = clog2_safe(MAX_OUTST + 1);
  localparam int TW = clog2_safe((TIMEOUT_CYC > 1) ? TIMEOUT_CYC : 2);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam bit            TO_EN     = (TIMEOUT_CYC > 0);

  ar_state_t         state;
  ar_state_t         state_nxt;
  logic              issue_go;
  logic              ar_hs;
  logic [ADDR_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OW-1:0]     outst;
  logic [TW-1:0]     to_cnt;
  logic              r_hs;
  logic              r_ok;
  logic              r_stray;
  logic              to_expire;
  logic              retire;

  rhandler_req_fifo #(
    .W     (ADDR_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (start),
    .wr_data (start_addr),
    .rd_en   (issue_go),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign start_ready = !fifo_full;
  assign busy        = !fifo_empty || (state == AR_ISSUE) || (outst != '0);

  // An R beat with nothing outstanding is a late or stray beat and is dropped.
  assign r_hs      = s_rvalid && s_rready;
  assign r_ok      = r_hs && (outst != '0);
  assign r_stray   = r_hs && (outst == '0);
  // A real R beat always wins over a same-cycle expiry.
  assign to_expire = TO_EN && (outst != '0) && !r_hs && (to_cnt == TO_LAST);
  assign retire    = r_ok || to_expire;

  // AR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= AR_IDLE;
    else        state <= state_nxt;
  end

  // AR next state: issue when work is queued and the outstanding budget allows.
  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE:  if (!fifo_empty && (outst < OUTST_MAX)) state_nxt = AR_ISSUE;
      AR_ISSUE: if (s_arready) state_nxt = AR_IDLE;
      default:  state_nxt = AR_IDLE;
    endcase
  end

  // AR control decode: pop on entering ISSUE, handshake while in ISSUE.
  always_comb begin
    issue_go = (state == AR_IDLE) && !fifo_empty && (outst < OUTST_MAX);
    ar_hs    = (state == AR_ISSUE) && s_arready;
  end

  // Registered AR channel; address is captured from the queue head on pop
  // and held until the slave accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_arvalid <= 1'b0;
      s_araddr  <= '0;
    end else if (issue_go) begin
      s_arvalid <= 1'b1;
      s_araddr  <= fifo_head;
    end else if (ar_hs) begin
      s_arvalid <= 1'b0;
    end
  end

  // R ready is always asserted once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_rready <= 1'b0;
    else        s_rready <= 1'b1;
  end

  // Outstanding count: AR handshake adds, completion or expiry removes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({ar_hs, retire})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // Timeout counter: counts silent cycles while reads are in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!TO_EN || (outst == '0) || r_hs || to_expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Completion outputs: one-cycle done pulse, payload held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      done_data    <= '0;
      done_resp    <= RESP_OKAY;
      done_timeout <= 1'b0;
    end else begin
      done <= retire;
      if (r_ok) begin
        done_data    <= s_rdata;
        done_resp    <= s_rresp;
        done_timeout <= 1'b0;
      end else if (to_expire) begin
        done_data    <= '0;
        done_resp    <= RESP_SLVERR;
        done_timeout <= 1'b1;
      end
    end
  end

  // Sticky stray-beat flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_stray <= 1'b0;
    else if (r_stray) err_stray <= 1'b1;
  end

endmodule
